// File: rtl/uart_rx_fifo.sv
// UART receiver with synchronised input, mid-bit sampling, optional parity,
// stop-bit checking and a show-ahead receive FIFO with sticky overrun.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_cfg_i,
  input  logic [15:0]                   bit_period_i,
  input  logic [1:0]                    parity_i,
  input  logic                          rx_en_i,
  input  logic                          uart_rxd_i,
  input  logic                          rd_i,
  output logic                          rx_valid_o,
  output logic [DATA_BITS-1:0]          rx_data_o,
  output logic                          rx_parity_err_o,
  output logic                          rx_frame_err_o,
  output logic                          overrun_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_BITS + 2;
  localparam logic [15:0] DEFAULT_BIT_PERIOD = 16'(CLK_FREQ / BAUD_RATE - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  logic                 rxd_m, rxd_s, rxd_q;
  logic [15:0]          bit_period_q;
  logic [1:0]           parity_q;
  state_e               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 perr_q, perr_d;
  logic                 push;
  logic [EW-1:0]        push_entry;
  logic                 par_en, tick;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {rxd_m, rxd_s, rxd_q} <= 3'b111;
      bit_period_q          <= DEFAULT_BIT_PERIOD;
      parity_q              <= 2'b00;
    end else begin
      rxd_m <= uart_rxd_i;
      rxd_s <= rxd_m;
      rxd_q <= rxd_s;
      if (wr_cfg_i) begin
        bit_period_q <= bit_period_i;
        parity_q     <= parity_i;
      end
    end
  end

  assign par_en = (parity_q == 2'b01) || (parity_q == 2'b10);
  assign tick   = (cnt_q == 16'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      perr_q    <= perr_d;
    end
  end

  // NOTE: every signal driven here gets a default first so no path can leave
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    perr_d     = perr_q;
    push       = 1'b0;
    push_entry = {~rxd_s, perr_q, shift_q};
    if (wr_cfg_i || !rx_en_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // Only a high-to-low transition starts a frame, so a held break is ignored.
          if (rxd_q && !rxd_s) begin
            cnt_d   = bit_period_q >> 1;
            state_d = S_START;
          end
        end
        S_START: begin
          if (!tick) cnt_d = cnt_q - 16'd1;
          else if (rxd_s) state_d = S_IDLE;
          else begin
            cnt_d     = bit_period_q;
            bit_cnt_d = '0;
            perr_d    = 1'b0;
            state_d   = S_DATA;
          end
        end
        S_DATA: begin
          if (!tick) cnt_d = cnt_q - 16'd1;
          else begin
            shift_d   = {rxd_s, shift_q[DATA_BITS-1:1]};
            cnt_d     = bit_period_q;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'(DATA_BITS - 1)) state_d = par_en ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (!tick) cnt_d = cnt_q - 16'd1;
          else begin
            // Odd mode (2'b10) expects the inverted XOR of the data.
            perr_d  = rxd_s != ((^shift_q) ^ parity_q[1]);
            cnt_d   = bit_period_q;
            state_d = S_STOP;
          end
        end
        S_STOP: begin
          if (!tick) cnt_d = cnt_q - 16'd1;
          else begin
            push    = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, pop, push_ok;
  logic [EW-1:0] head;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign pop     = rd_i && !empty;
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overrun_o <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + CW'(1);
      if (pop)     rd_ptr <= rd_ptr + CW'(1);
      if (wr_cfg_i)                 overrun_o <= 1'b0;
      else if (push && full && !pop) overrun_o <= 1'b1;
    end
  end

  // NOTE: storage is left unreset; entries are only visible once written, and
  // the outputs are gated to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  assign head            = mem[rd_ptr[AW-1:0]];
  assign rx_valid_o      = !empty;
  assign rx_data_o       = empty ? '0 : head[DATA_BITS-1:0];
  assign rx_parity_err_o = !empty && head[DATA_BITS];
  assign rx_frame_err_o  = !empty && head[DATA_BITS+1];
  assign fifo_count_o    = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised bench for uart_rx_fifo: serial frames are driven bit by bit and
// compared against a queue-based model of the received-frame FIFO.
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_cfg_i = 1'b0;
  logic [15:0] bit_period_i = '0;
  logic [1:0]  parity_i = '0;
  logic        rx_en_i = 1'b0;
  logic        uart_rxd_i = 1'b1;
  logic        rd_i = 1'b0;
  logic        rx_valid_o;
  logic [7:0]  rx_data_o;
  logic        rx_parity_err_o;
  logic        rx_frame_err_o;
  logic        overrun_o;
  logic [2:0]  fifo_count_o;

  uart_rx_fifo #(.CLK_FREQ(50000000), .BAUD_RATE(115200), .DATA_BITS(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_cfg_i(wr_cfg_i), .bit_period_i(bit_period_i),
    .parity_i(parity_i), .rx_en_i(rx_en_i), .uart_rxd_i(uart_rxd_i), .rd_i(rd_i),
    .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o), .rx_parity_err_o(rx_parity_err_o),
    .rx_frame_err_o(rx_frame_err_o), .overrun_o(overrun_o), .fifo_count_o(fifo_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } entry_t;

  entry_t     model_q[$];
  logic       model_ovr = 1'b0;
  int         cur_bp = 433;
  logic [1:0] cur_par = 2'b00;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_push(input logic [7:0] d, input logic perr, input logic ferr);
    entry_t e;
    e.data = d;
    e.perr = perr;
    e.ferr = ferr;
    if (model_q.size() < 4) model_q.push_back(e);
    else model_ovr = 1'b1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, 32'(fifo_count_o), 32'(model_q.size()));
    check({tag, "_valid"}, 32'(rx_valid_o), 32'(model_q.size() != 0));
    check({tag, "_overrun"}, 32'(overrun_o), 32'(model_ovr));
    if (model_q.size() != 0) begin
      check({tag, "_data"}, 32'(rx_data_o), 32'(model_q[0].data));
      check({tag, "_perr"}, 32'(rx_parity_err_o), 32'(model_q[0].perr));
      check({tag, "_ferr"}, 32'(rx_frame_err_o), 32'(model_q[0].ferr));
    end else begin
      check({tag, "_empty_out"}, {29'd0, rx_data_o == 8'd0, rx_parity_err_o, rx_frame_err_o},
            32'h4);
    end
  endtask

  task automatic pop_one(input string tag);
    check_state(tag);
    rd_i = 1'b1;
    tick(1);
    rd_i = 1'b0;
    if (model_q.size() != 0) void'(model_q.pop_front());
    check({tag, "_after_pop"}, 32'(fifo_count_o), 32'(model_q.size()));
  endtask

  task automatic do_cfg(input int bp, input logic [1:0] par);
    wr_cfg_i     = 1'b1;
    bit_period_i = 16'(bp);
    parity_i     = par;
    tick(1);
    wr_cfg_i  = 1'b0;
    cur_bp    = bp;
    cur_par   = par;
    model_ovr = 1'b0;
  endtask

  task automatic drive_bit(input logic v);
    uart_rxd_i = v;
    tick(cur_bp + 1);
  endtask

  // Sends one frame in the current format; bad_par flips the parity bit,
  // bad_stop drives the stop bit low, hold_low extends the low line afterwards.
  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop,
                            input int hold_low);
    logic par_en;
    par_en = (cur_par == 2'b01) || (cur_par == 2'b10);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (par_en) drive_bit((^d) ^ (cur_par == 2'b10) ^ bad_par);
    drive_bit(!bad_stop);
    if (bad_stop && hold_low > 0) begin
      uart_rxd_i = 1'b0;
      tick(hold_low);
      check("break_no_retrigger", 32'(fifo_count_o), 32'(model_q.size() < 4 ? model_q.size() + 1 : 4));
    end
    uart_rxd_i = 1'b1;
    tick(2 * (cur_bp + 1) + 4);
    model_push(d, par_en && bad_par, bad_stop);
  endtask

  initial begin
    tick(3);
    rst_n   = 1'b1;
    rx_en_i = 1'b1;
    tick(2);
    check_state("reset");
    pop_one("rd_empty");

    // Reset bit period (433) and no parity.
    send_frame(8'h5A, 1'b0, 1'b0, 0);
    check_state("default_rate");
    pop_one("default_rate_pop");

    do_cfg(15, 2'b00);
    send_frame(8'hA5, 1'b0, 1'b0, 0);
    check_state("basic");
    pop_one("basic_pop");
    check_state("basic_empty");

    do_cfg(15, 2'b01);
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    send_frame(8'h3C, 1'b1, 1'b0, 0);
    pop_one("even_ok");
    pop_one("even_bad");
    do_cfg(15, 2'b10);
    send_frame(8'h3D, 1'b0, 1'b0, 0);
    send_frame(8'h3D, 1'b1, 1'b0, 0);
    pop_one("odd_ok");
    pop_one("odd_bad");

    do_cfg(15, 2'b00);
    send_frame(8'h55, 1'b0, 1'b1, 120);
    check_state("frame_err");
    send_frame(8'h12, 1'b0, 1'b0, 0);
    pop_one("frame_err_pop");
    pop_one("after_break_pop");

    // Four-cycle glitch must be rejected as a false start.
    uart_rxd_i = 1'b0;
    tick(4);
    uart_rxd_i = 1'b1;
    tick(48);
    check_state("false_start");
    send_frame(8'h12, 1'b0, 1'b0, 0);
    pop_one("after_glitch");

    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0, 0);
    check_state("overrun");
    for (int i = 0; i < 4; i++) pop_one("overrun_drain");
    check_state("overrun_sticky");
    do_cfg(15, 2'b00);
    check_state("overrun_clear");

    // rx_en_i dropped partway through the data bits of 0x77.
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    rx_en_i = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    tick(20);
    rx_en_i = 1'b1;
    tick(20);
    check_state("abort_en");
    send_frame(8'h81, 1'b0, 1'b0, 0);
    pop_one("after_abort_en");

    // Reconfiguration to bit period 7 in the middle of a frame.
    drive_bit(1'b0);
    drive_bit(1'b1);
    uart_rxd_i = 1'b0;
    tick(5);
    do_cfg(7, 2'b00);
    uart_rxd_i = 1'b1;
    tick(40);
    check_state("abort_cfg");
    send_frame(8'h3E, 1'b0, 1'b0, 0);
    pop_one("new_rate");

    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 5) == 0)
        do_cfg(int'($urandom_range(7, 20)), 2'($urandom_range(0, 3)));
      send_frame(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, 0);
      check_state("rnd");
      repeat ($urandom_range(0, 2)) pop_one("rnd_pop");
    end
    while (model_q.size() != 0) pop_one("drain");
    check_state("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
